ep_arith_engine: RTL and testbench

EP_ARITH_ENGINE -- requirements
Module: ep_arith_engine

---
 rtl/ep_arith_pkg.sv | 29 ++
 rtl/ep_arith_iter.sv | 56 +++++
 rtl/ep_arith_engine.sv | 152 +++++++++++++++
 tb/tb_ep_arith_engine.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ep_arith_pkg.sv
// Shared definitions for the FrontPanel arithmetic engine.
// Op codes, FSM states and status word bit positions.
package ep_arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_DIV = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam int ST_BUSY = 0;
  localparam int ST_DSTK = 1;
  localparam int ST_ERR  = 2;
  localparam int ST_OVR  = 3;
  localparam int ST_OP   = 4;

  // Multiply and non-zero divide iterate once per operand bit.
  function automatic logic is_long(op_e f_op, logic f_bz);
    return (f_op == OP_MUL) || ((f_op == OP_DIV) && !f_bz);
  endfunction

endpackage

// File: rtl/ep_arith_iter.sv
// One-bit-per-cycle shift-add multiplier / restoring divider.
// o_nhi/o_nlo show the register values after the current step.
module ep_arith_iter
  import ep_arith_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_nhi,
  output logic [WIDTH-1:0] o_nlo
);

  logic [WIDTH-1:0] r_hi, r_lo, r_m;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_t;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;

  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);

  assign w_t   = {r_hi, r_lo[WIDTH-1]};
  assign w_ge  = (w_t >= {1'b0, r_m});
  // Only used when w_ge holds, so the true difference fits WIDTH bits.
  assign w_sub = w_t[WIDTH-1:0] - r_m;

  always_comb begin
    o_nhi = w_sum[WIDTH:1];
    o_nlo = {w_sum[0], r_lo[WIDTH-1:1]};
    if (i_div) begin
      o_nhi = w_ge ? w_sub : w_t[WIDTH-1:0];
      o_nlo = {r_lo[WIDTH-2:0], w_ge};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hi <= '0;
      r_lo <= '0;
      r_m  <= '0;
    end else if (i_load) begin
      r_hi <= '0;
      r_lo <= i_a;
      r_m  <= i_b;
    end else if (i_step) begin
      r_hi <= o_nhi;
      r_lo <= o_nlo;
    end
  end

endmodule

// File: rtl/ep_arith_engine.sv
// Host-triggered add / multiply / divide engine with sticky status,
// sitting between FrontPanel wire-in, trigger-in and wire-out endpoints.
module ep_arith_engine
  import ep_arith_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             okClk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [31:0]      status,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  state_e           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  op_e              r_op;
  logic [WIDTH-1:0] r_a, r_b, r_lo, r_hi;
  logic             r_done, r_dstk, r_err, r_ovr;
  logic             w_accept, w_last, w_err;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_it_lo, w_it_hi, w_res_lo, w_res_hi;

  assign w_accept = start && (r_state == S_IDLE);
  assign w_last   = (r_state == S_RUN) && (r_cnt == '0);
  assign w_sum    = {1'b0, r_a} + {1'b0, r_b};

  ep_arith_iter #(.WIDTH(WIDTH)) u_iter (
    .i_clk  (okClk),
    .i_rst  (reset),
    .i_load (w_accept),
    .i_step (r_state == S_RUN),
    .i_div  (r_op == OP_DIV),
    .i_a    (a),
    .i_b    (b),
    .o_nhi  (w_it_hi),
    .o_nlo  (w_it_lo)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (r_cnt == '0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge okClk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Counter holds remaining RUN cycles minus one.
  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= is_long(op_e'(op), b == '0) ? CW'(WIDTH - 1) : '0;
    end else if ((r_state == S_RUN) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= OP_ADD;
    end else if (w_accept) begin
      r_a  <= a;
      r_b  <= b;
      r_op <= op_e'(op);
    end
  end

  always_comb begin
    w_res_lo = '0;
    w_res_hi = '0;
    w_err    = 1'b0;
    unique case (r_op)
      OP_ADD: begin
        w_res_lo = w_sum[WIDTH-1:0];
        w_res_hi = WIDTH'(w_sum[WIDTH]);
      end
      OP_MUL: begin
        w_res_lo = w_it_lo;
        w_res_hi = w_it_hi;
      end
      OP_DIV: begin
        if (r_b == '0) begin
          w_res_lo = '1;
          w_res_hi = r_a;
          w_err    = 1'b1;
        end else begin
          w_res_lo = w_it_lo;
          w_res_hi = w_it_hi;
        end
      end
      OP_RSV:  w_err = 1'b1;
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      r_lo   <= '0;
      r_hi   <= '0;
      r_done <= 1'b0;
      r_dstk <= 1'b0;
      r_err  <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_last) begin
        r_lo   <= w_res_lo;
        r_hi   <= w_res_hi;
        r_dstk <= 1'b1;
        r_err  <= w_err;
      end
      if (w_accept) begin
        r_dstk <= 1'b0;
        r_err  <= 1'b0;
        r_ovr  <= 1'b0;
      end else if (start) begin
        r_ovr  <= 1'b1;
      end
    end
  end

  always_comb begin
    status             = '0;
    status[ST_BUSY]    = (r_state != S_IDLE);
    status[ST_DSTK]    = r_dstk;
    status[ST_ERR]     = r_err;
    status[ST_OVR]     = r_ovr;
    status[ST_OP +: 2] = r_op;
  end

  assign result_lo = r_lo;
  assign result_hi = r_hi;
  assign done      = r_done;

endmodule

// File: tb/tb_ep_arith_engine.sv
// Bench for ep_arith_engine: operation-level model plus directed vectors.
module tb_ep_arith_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] result_lo, result_hi, status;
  logic        done;

  int checks = 0;
  int errors = 0;

  ep_arith_engine #(.WIDTH(32)) dut (
    .okClk     (clk),
    .reset     (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .status    (status),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Operation-level model: one pending operation with a due cycle.
  int          cyc = 0;
  int          due = 0;
  bit          m_pend = 0, m_busy = 0, m_done = 0;
  bit          m_err = 0, m_dst = 0, m_ovr = 0;
  logic [1:0]  m_op = 0;
  logic [31:0] m_lo = 0, m_hi = 0, p_lo = 0, p_hi = 0;
  bit          p_err = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; m_pend = 0; m_busy = 0; m_done = 0;
      m_err = 0; m_dst = 0; m_ovr = 0; m_op = 0;
      m_lo = 0; m_hi = 0;
    end else begin
      bit          was_busy;
      logic [63:0] r;
      int          n;
      cyc++;
      was_busy = m_pend;
      m_done = 0;
      if (m_pend && cyc == due) begin
        m_done = 1; m_lo = p_lo; m_hi = p_hi;
        m_err = p_err; m_dst = 1;
      end
      if (m_pend && cyc == due + 1) m_pend = 0;
      if (start) begin
        if (was_busy) m_ovr = 1;
        else begin
          p_err = 0;
          case (op)
            2'd0: begin r = {32'd0, a} + {32'd0, b}; n = 1; end
            2'd1: begin r = {32'd0, a} * {32'd0, b}; n = 32; end
            2'd2: begin
              if (b == 0) begin r = {a, 32'hFFFF_FFFF}; n = 1; p_err = 1; end
              else begin r = {a % b, a / b}; n = 32; end
            end
            default: begin r = 0; n = 1; p_err = 1; end
          endcase
          p_lo = r[31:0]; p_hi = r[63:32];
          due = cyc + n; m_pend = 1;
          m_ovr = 0; m_err = 0; m_dst = 0; m_op = op;
        end
      end
      m_busy = m_pend;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_done", done, m_done);
      chk("cmp_lo", result_lo, m_lo);
      chk("cmp_hi", result_hi, m_hi);
      chk("cmp_status", status,
          {26'd0, m_op, m_ovr, m_err, m_dst, m_busy});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one op from an IDLE cycle; returns in the IDLE cycle after DONE.
  task automatic run_op(input string nm, input logic [1:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input int lat, input logic [31:0] elo,
                        input logic [31:0] ehi, input logic eerr);
    int n;
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({nm, "_busy"}, status[0], 1'b1);
        chk({nm, "_ovr_clr"}, status[3], 1'b0);
      end
    end while (!done && n < 100);
    chk({nm, "_done_seen"}, done, 1'b1);
    chk({nm, "_lat"}, n, lat);
    chk({nm, "_lo"}, result_lo, elo);
    chk({nm, "_hi"}, result_hi, ehi);
    chk({nm, "_err"}, status[2], eerr);
    chk({nm, "_dstk"}, status[1], 1'b1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dones;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lo", result_lo, 32'h0);
    chk("rst_hi", result_hi, 32'h0);
    chk("rst_status", status, 32'h0);
    chk("rst_done", done, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Back-to-back ops: each run_op starts in the cycle after DONE.
    run_op("add_carry", 2'd0, 32'hFFFF_FFFF, 32'h1, 2, 32'h0, 32'h1, 1'b0);
    run_op("mul_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33,
           32'h1, 32'hFFFF_FFFE, 1'b0);
    run_op("div_100_7", 2'd2, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0);
    run_op("div_by0", 2'd2, 32'd5, 32'd0, 2, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run_op("rsv", 2'd3, 32'h1234, 32'h5678, 2, 32'h0, 32'h0, 1'b1);
    run_op("add_small", 2'd0, 32'd3, 32'd4, 2, 32'd7, 32'd0, 1'b0);
    run_op("mul_2p32", 2'd1, 32'h1_0000, 32'h1_0000, 33,
           32'h0, 32'h1, 1'b0);
    run_op("mul_6x7", 2'd1, 32'd6, 32'd7, 33, 32'd42, 32'd0, 1'b0);
    run_op("div_by1", 2'd2, 32'hFFFF_FFFF, 32'd1, 33,
           32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op("div_small", 2'd2, 32'd7, 32'd100, 33, 32'd0, 32'd7, 1'b0);
    run_op("div_by3", 2'd2, 32'h8000_0000, 32'd3, 33,
           32'h2AAA_AAAA, 32'd2, 1'b0);
    run_op("add_msb", 2'd0, 32'h8000_0000, 32'h8000_0000, 2,
           32'h0, 32'h1, 1'b0);

    // Overrun: operand change and a stray start during a multiply.
    op = 2'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    a = 32'h0; b = 32'h3;
    repeat (4) tick();
    op = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("ovr_set", status[3], 1'b1);
    dones = 0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ovr_done_seen", done, 1'b1);
    chk("ovr_mul_lo", result_lo, 32'h1);
    chk("ovr_mul_hi", result_hi, 32'hFFFF_FFFE);
    chk("ovr_kept", status[3], 1'b1);
    chk("ovr_lastop", status[5:4], 2'd1);
    repeat (5) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("ovr_no_extra_done", dones, 0);
    tick();
    run_op("after_ovr", 2'd0, 32'd10, 32'd20, 2, 32'd30, 32'd0, 1'b0);

    // Reset in the middle of a multiply.
    op = 2'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_lo", result_lo, 32'h0);
    chk("mid_rst_hi", result_hi, 32'h0);
    chk("mid_rst_status", status, 32'h0);
    chk("mid_rst_done", done, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("mid_rst_no_done", dones, 0);
    tick();
    run_op("post_rst_add", 2'd0, 32'd1, 32'd2, 2, 32'd3, 32'd0, 1'b0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
